ibex_wb_result_buffer: RTL and testbench
========================================

Name: ibex_wb_result_buffer

Overview:
- Writeback-side stage directly downstream of the execution block.
- Captures completed EX results (ALU, MUL/DIV or IPM) in a 2-entry in-order buffer and drains them to the register-file write port under an `rf_ready_i` backpressure handshake.
- Provides register forwarding to ID for buffered results, plus retirement counters.
- Decouples EX completion from register-file port contention, such as LSU writeback.

Parameters:
- `Depth`, default 2: number of buffer entries; fixed at 2, other values unsupported.
- `IpmCntWidth`, default 16: width of the IPM retirement counter.

Ports:
- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `ex_valid_i`  input  1  EX has a completed instruction this cycle.
- `ex_ready_o`  output  1  buffer can accept an entry.
- `ex_result_i`  input  32  EX result value.
- `ex_rd_addr_i`  input  5  destination register.
- `ex_rd_we_i`  input  1  instruction writes rd.
- `ex_ipm_i`  input  1  result came from the IPM unit.
- `flush_i`  input  1  discard all buffered entries.
- `rf_we_o`  output  1  register-file write request.
- `rf_waddr_o`  output  5  write address.
- `rf_wdata_o`  output  32  write data.
- `rf_ready_i`  input  1  register-file port grants the write this cycle.
- `id_rs1_addr_i`  input  5  ID source register 1.
- `id_rs2_addr_i`  input  5  ID source register 2.
- `fwd_rs1_hit_o`  output  1  buffered value available for rs1.
- `fwd_rs1_data_o`  output  32  forwarded rs1 value.
- `fwd_rs2_hit_o`  output  1  buffered value available for rs2.
- `fwd_rs2_data_o`  output  32  forwarded rs2 value.
- `occupancy_o`  output  2  entries held (0..2).
- `retire_cnt_o`  output  32  instructions drained.
- `ipm_retire_cnt_o`  output  IpmCntWidth  IPM instructions drained.

Behaviour:
- Reset (`rst_i`=1 at a clock edge): occupancy, pointers and both counters go to 0; entry valid bits are cleared.
  - While empty: `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0, both `fwd_*_hit_o`=0, both `fwd_*_data_o`=0, `ex_ready_o`=1.
  - Reset overrides `flush_i` and any push or pop in the same cycle.
- Storage: circular FIFO with 1-bit head and tail pointers. Each entry holds `{result, rd_addr, rd_we, ipm}`.
- `ex_ready_o` = (occupancy < 2). It is decoded from state only, with no combinational path from `rf_ready_i` or `ex_valid_i`.
- Push: `ex_valid_i` & `ex_ready_o` & !`flush_i`. The entry is written at tail and tail advances.
  - When full, no push happens even if a pop occurs in the same cycle.
- Head presentation (combinational from state):
  - `rf_we_o` = head valid & head `rd_we` & (head `rd_addr` != 0) & !`flush_i`.
  - `rf_waddr_o` and `rf_wdata_o` show the head fields when occupancy > 0, otherwise 0.
- Pop rules:
  - A writing head pops when `rf_we_o` & `rf_ready_i`.
  - A non-writing head (`rd_we`=0 or rd=x0) pops unconditionally the cycle after it becomes head, with `rf_we_o`=0 and `rf_ready_i` ignored.
  - A head with `rf_ready_i`=0 holds with stable address and data.
- Latency:
  - An entry pushed at edge N is presented from cycle N+1.
  - Minimum EX-to-RF latency is 1 cycle.
  - Sustained throughput is 1 entry per cycle when `rf_ready_i`=1.
- Simultaneous push and pop at occupancy 1: occupancy stays 1 and order is preserved.
- Flush: `flush_i`=1 sets occupancy to 0 and clears valid bits.
  - No write is issued in that cycle, no push occurs, and counters do not increment.
  - Pointers reset to 0.
- Counters increment by 1 per pop and wrap modulo 2^width:
  - `retire_cnt_o` counts every pop, writing or not.
  - `ipm_retire_cnt_o` counts pops whose entry has `ipm`=1.
- Forwarding, evaluated per source:
  - Hit = some valid entry with `rd_we`=1, `rd_addr` == source, and source != 0.
  - If both entries match, the younger entry (the one at tail-1) wins.
  - Data is 0 when there is no hit.
  - Forwarding is purely combinational from state and ignores the current-cycle `ex_*` inputs.
  - During a flush cycle the hits are 0.
- `occupancy_o` reflects registered state.

Test Plan:
- Reset then single push: result=0xDEADBEEF, rd=5, we=1, `rf_ready_i`=1 → `rf_we_o`=1, `rf_waddr_o`=5, `rf_wdata_o`=0xDEADBEEF one cycle later; `retire_cnt_o`=1 afterwards; occupancy returns to 0.
- Backpressure: `rf_ready_i`=0 while pushing 3 back-to-back entries → 2 accepted, `ex_ready_o`=0 at occupancy 2, third entry held upstream; raising `rf_ready_i` drains the entries in order with stable data while stalled.
- Forwarding priority: buffer holds rd=7 (0x11) then rd=7 (0x22); `id_rs1_addr_i`=7 → `fwd_rs1_hit_o`=1, data 0x22; `id_rs2_addr_i`=0 → hit=0; after both drain, both hits are 0.
- Non-writing entries: push we=0 and rd=0 with we=1, holding `rf_ready_i`=0 → both pop in consecutive cycles, `rf_we_o` never asserted, `retire_cnt_o` += 2.
- Flush mid-operation: occupancy 2, `rf_ready_i`=0, assert `flush_i` with `ex_valid_i`=1 → no write, no push, occupancy 0 next cycle, counters unchanged; reset asserted mid-drain → all outputs 0 next cycle.
- Counter wrap: preload via 65536 IPM pops (or force) → `ipm_retire_cnt_o` wraps to 0 while `retire_cnt_o`=65536.

Source files
------------

// File: rtl/ibex_wb_result_buffer.sv
// Two-entry in-order writeback buffer between EX and the register-file write port.
// Drains under rf_ready_i backpressure and forwards buffered results to ID.
module ibex_wb_result_buffer #(
  parameter int unsigned Depth       = 2,
  parameter int unsigned IpmCntWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ex_valid_i,
  output logic                   ex_ready_o,
  input  logic [31:0]            ex_result_i,
  input  logic [4:0]             ex_rd_addr_i,
  input  logic                   ex_rd_we_i,
  input  logic                   ex_ipm_i,
  input  logic                   flush_i,
  output logic                   rf_we_o,
  output logic [4:0]             rf_waddr_o,
  output logic [31:0]            rf_wdata_o,
  input  logic                   rf_ready_i,
  input  logic [4:0]             id_rs1_addr_i,
  input  logic [4:0]             id_rs2_addr_i,
  output logic                   fwd_rs1_hit_o,
  output logic [31:0]            fwd_rs1_data_o,
  output logic                   fwd_rs2_hit_o,
  output logic [31:0]            fwd_rs2_data_o,
  output logic [1:0]             occupancy_o,
  output logic [31:0]            retire_cnt_o,
  output logic [IpmCntWidth-1:0] ipm_retire_cnt_o
);

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        ipm;
  } entry_t;

  entry_t [1:0]           mem_q, mem_d;
  logic   [1:0]           valid_q, valid_d;
  logic                   head_q, head_d;
  logic                   tail_q, tail_d;
  logic   [1:0]           occ_q, occ_d;
  logic   [31:0]          retire_q, retire_d;
  logic [IpmCntWidth-1:0] ipm_cnt_q, ipm_cnt_d;

  entry_t      head_e;
  logic        head_vld, head_wr, push, pop;
  logic [4:0]  src [2];
  logic        hit [2];
  logic [31:0] fdata [2];

  assign ex_ready_o       = (occ_q != 2'(Depth));
  assign occupancy_o      = occ_q;
  assign retire_cnt_o     = retire_q;
  assign ipm_retire_cnt_o = ipm_cnt_q;

  always_comb begin
    head_e   = mem_q[head_q];
    head_vld = valid_q[head_q];
    // rd=x0 writes are architecturally dropped, so they drain like non-writing entries
    head_wr  = head_e.rd_we & (head_e.rd_addr != 5'd0);

    rf_we_o    = head_vld & head_wr & ~flush_i;
    rf_waddr_o = (occ_q != 2'd0) ? head_e.rd_addr : 5'd0;
    rf_wdata_o = (occ_q != 2'd0) ? head_e.result  : 32'd0;

    push = ex_valid_i & ex_ready_o & ~flush_i;
    pop  = head_vld & ~flush_i & (~head_wr | rf_ready_i);
  end

  always_comb begin
    mem_d     = mem_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    occ_d     = occ_q;
    retire_d  = retire_q;
    ipm_cnt_d = ipm_cnt_q;
    if (flush_i) begin
      valid_d = 2'b00;
      head_d  = 1'b0;
      tail_d  = 1'b0;
      occ_d   = 2'd0;
    end else begin
      if (push) begin
        mem_d[tail_q]   = '{result: ex_result_i, rd_addr: ex_rd_addr_i,
                            rd_we: ex_rd_we_i, ipm: ex_ipm_i};
        valid_d[tail_q] = 1'b1;
        tail_d          = ~tail_q;
      end
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = ~head_q;
        retire_d        = retire_q + 32'd1;
        ipm_cnt_d       = ipm_cnt_q + IpmCntWidth'(head_e.ipm);
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Older entry (at tail) is checked first so the younger one (tail-1) overrides it.
  always_comb begin
    src[0] = id_rs1_addr_i;
    src[1] = id_rs2_addr_i;
    for (int s = 0; s < 2; s++) begin
      hit[s]   = 1'b0;
      fdata[s] = 32'd0;
      if (!flush_i && src[s] != 5'd0) begin
        if (valid_q[tail_q] && mem_q[tail_q].rd_we && mem_q[tail_q].rd_addr == src[s]) begin
          hit[s]   = 1'b1;
          fdata[s] = mem_q[tail_q].result;
        end
        if (valid_q[~tail_q] && mem_q[~tail_q].rd_we && mem_q[~tail_q].rd_addr == src[s]) begin
          hit[s]   = 1'b1;
          fdata[s] = mem_q[~tail_q].result;
        end
      end
    end
    fwd_rs1_hit_o  = hit[0];
    fwd_rs1_data_o = fdata[0];
    fwd_rs2_hit_o  = hit[1];
    fwd_rs2_data_o = fdata[1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 2'b00;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      occ_q     <= 2'd0;
      retire_q  <= 32'd0;
      ipm_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      retire_q  <= retire_d;
      ipm_cnt_q <= ipm_cnt_d;
    end
  end

  // Payload is qualified by valid bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ibex_wb_result_buffer.sv
// Directed bench for ibex_wb_result_buffer with a write scoreboard on the RF port.
module tb_ibex_wb_result_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i, ex_valid_i, ex_ready_o, ex_rd_we_i, ex_ipm_i, flush_i;
  logic [31:0] ex_result_i, rf_wdata_o, fwd_rs1_data_o, fwd_rs2_data_o, retire_cnt_o;
  logic [4:0]  ex_rd_addr_i, rf_waddr_o, id_rs1_addr_i, id_rs2_addr_i;
  logic        rf_we_o, rf_ready_i, fwd_rs1_hit_o, fwd_rs2_hit_o;
  logic [1:0]  occupancy_o;
  logic [15:0] ipm_retire_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];

  always #5 clk_i = ~clk_i;

  ibex_wb_result_buffer #(.Depth(2), .IpmCntWidth(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_result_i(ex_result_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_we_i(ex_rd_we_i), .ex_ipm_i(ex_ipm_i),
    .flush_i(flush_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_ready_i(rf_ready_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .fwd_rs1_hit_o(fwd_rs1_hit_o), .fwd_rs1_data_o(fwd_rs1_data_o),
    .fwd_rs2_hit_o(fwd_rs2_hit_o), .fwd_rs2_data_o(fwd_rs2_data_o),
    .occupancy_o(occupancy_o), .retire_cnt_o(retire_cnt_o), .ipm_retire_cnt_o(ipm_retire_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [31:0] res, input logic ipm);
    ex_valid_i   = v;
    ex_rd_addr_i = rd;
    ex_rd_we_i   = we;
    ex_result_i  = res;
    ex_ipm_i     = ipm;
  endtask

  // Every granted write is matched against the oldest expected write.
  always @(negedge clk_i) begin
    if (!rst_i && rf_we_o && rf_ready_i) begin
      if (sb.size() == 0) chk("sb_unexpected_write", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("sb_addr", 32'(rf_waddr_o), 32'(e.addr));
        chk("sb_data", rf_wdata_o, e.data);
      end
    end
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; rf_ready_i = 1'b0;
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    tick(); tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);
    chk("rst_rf_we", 32'(rf_we_o), 32'd0);
    chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_occ", 32'(occupancy_o), 32'd0);
    chk("rst_retire", retire_cnt_o, 32'd0);
    chk("rst_ipm", 32'(ipm_retire_cnt_o), 32'd0);
    chk("rst_hit1", 32'(fwd_rs1_hit_o), 32'd0);

    // single push, 1-cycle latency
    tick();
    rf_ready_i = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0);
    sb.push_back('{5'd5, 32'hDEADBEEF});
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk_i);
    chk("single_rf_we", 32'(rf_we_o), 32'd1);
    chk("single_waddr", 32'(rf_waddr_o), 32'd5);
    chk("single_wdata", rf_wdata_o, 32'hDEADBEEF);
    chk("single_occ", 32'(occupancy_o), 32'd1);
    tick();
    @(negedge clk_i);
    chk("single_occ_after", 32'(occupancy_o), 32'd0);
    chk("single_retire", retire_cnt_o, 32'd1);

    // backpressure: third entry held upstream until a slot frees
    rf_ready_i = 1'b0;
    sb.push_back('{5'd1, 32'h100});
    sb.push_back('{5'd2, 32'h200});
    sb.push_back('{5'd3, 32'h300});
    drive(1'b1, 5'd1, 1'b1, 32'h100, 1'b0); tick();
    drive(1'b1, 5'd2, 1'b1, 32'h200, 1'b0); tick();
    drive(1'b1, 5'd3, 1'b1, 32'h300, 1'b0);
    @(negedge clk_i);
    chk("bp_occ_full", 32'(occupancy_o), 32'd2);
    chk("bp_ex_ready", 32'(ex_ready_o), 32'd0);
    chk("bp_stall_addr0", 32'(rf_waddr_o), 32'd1);
    tick();
    @(negedge clk_i);
    chk("bp_occ_held", 32'(occupancy_o), 32'd2);
    chk("bp_stall_addr1", 32'(rf_waddr_o), 32'd1);
    chk("bp_stall_data1", rf_wdata_o, 32'h100);
    tick();
    rf_ready_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("bp_full_no_push", 32'(occupancy_o), 32'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk_i);
    chk("bp_push_pop_occ", 32'(occupancy_o), 32'd1);
    chk("bp_order_addr", 32'(rf_waddr_o), 32'd3);
    tick();
    @(negedge clk_i);
    chk("bp_drained_occ", 32'(occupancy_o), 32'd0);
    chk("bp_retire", retire_cnt_o, 32'd4);

    // forwarding priority: younger rd=7 wins
    rf_ready_i = 1'b0;
    sb.push_back('{5'd7, 32'h11});
    sb.push_back('{5'd7, 32'h22});
    drive(1'b1, 5'd7, 1'b1, 32'h11, 1'b0); tick();
    drive(1'b1, 5'd7, 1'b1, 32'h22, 1'b0); tick();
    drive(1'b1, 5'd9, 1'b1, 32'h99, 1'b0);
    id_rs1_addr_i = 5'd7; id_rs2_addr_i = 5'd0;
    @(negedge clk_i);
    chk("fwd_rs1_hit", 32'(fwd_rs1_hit_o), 32'd1);
    chk("fwd_rs1_data", fwd_rs1_data_o, 32'h22);
    chk("fwd_rs2_x0_hit", 32'(fwd_rs2_hit_o), 32'd0);
    chk("fwd_rs2_x0_data", fwd_rs2_data_o, 32'd0);
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    id_rs2_addr_i = 5'd9;
    @(negedge clk_i);
    chk("fwd_ignores_ex", 32'(fwd_rs2_hit_o), 32'd0);
    rf_ready_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("fwd_after_one_pop", fwd_rs1_data_o, 32'h22);
    tick();
    @(negedge clk_i);
    chk("fwd_drained_hit1", 32'(fwd_rs1_hit_o), 32'd0);
    chk("fwd_drained_hit2", 32'(fwd_rs2_hit_o), 32'd0);
    chk("fwd_retire", retire_cnt_o, 32'd6);

    // non-writing entries drain with ready low and never request a write
    rf_ready_i = 1'b0;
    id_rs1_addr_i = 5'd4; id_rs2_addr_i = 5'd0;
    drive(1'b1, 5'd4, 1'b0, 32'hAAA, 1'b0); tick();
    drive(1'b1, 5'd0, 1'b1, 32'hBBB, 1'b0);
    @(negedge clk_i);
    chk("nw_rf_we0", 32'(rf_we_o), 32'd0);
    chk("nw_no_fwd_we0", 32'(fwd_rs1_hit_o), 32'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk_i);
    chk("nw_rf_we1", 32'(rf_we_o), 32'd0);
    chk("nw_occ", 32'(occupancy_o), 32'd1);
    tick();
    @(negedge clk_i);
    chk("nw_occ_empty", 32'(occupancy_o), 32'd0);
    chk("nw_retire", retire_cnt_o, 32'd8);

    // flush at full and at occupancy 1 with a concurrent EX valid
    drive(1'b1, 5'd10, 1'b1, 32'h1, 1'b1); tick();
    drive(1'b1, 5'd11, 1'b1, 32'h2, 1'b1); tick();
    drive(1'b1, 5'd12, 1'b1, 32'h3, 1'b1);
    flush_i = 1'b1; id_rs1_addr_i = 5'd10;
    @(negedge clk_i);
    chk("fl_rf_we", 32'(rf_we_o), 32'd0);
    chk("fl_hit", 32'(fwd_rs1_hit_o), 32'd0);
    tick();
    flush_i = 1'b0;
    drive(1'b1, 5'd13, 1'b1, 32'h4, 1'b0);
    @(negedge clk_i);
    chk("fl_occ", 32'(occupancy_o), 32'd0);
    chk("fl_retire", retire_cnt_o, 32'd8);
    chk("fl_ipm", 32'(ipm_retire_cnt_o), 32'd0);
    tick();
    drive(1'b1, 5'd14, 1'b1, 32'h5, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk_i);
    chk("fl_no_push_occ", 32'(occupancy_o), 32'd0);

    // reset mid-drain
    drive(1'b1, 5'd15, 1'b1, 32'h6, 1'b1); tick();
    drive(1'b1, 5'd16, 1'b1, 32'h7, 1'b1); tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    rf_ready_i = 1'b1; rst_i = 1'b1; id_rs1_addr_i = 5'd16;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mrst_occ", 32'(occupancy_o), 32'd0);
    chk("mrst_rf_we", 32'(rf_we_o), 32'd0);
    chk("mrst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("mrst_wdata", rf_wdata_o, 32'd0);
    chk("mrst_hit", 32'(fwd_rs1_hit_o), 32'd0);
    chk("mrst_retire", retire_cnt_o, 32'd0);
    chk("mrst_ex_ready", 32'(ex_ready_o), 32'd1);

    // IPM counter wrap with back-to-back non-writing IPM entries
    drive(1'b1, 5'd0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 65535; i++) tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    tick(); tick();
    @(negedge clk_i);
    chk("wrap_ipm_max", 32'(ipm_retire_cnt_o), 32'hFFFF);
    chk("wrap_retire_pre", retire_cnt_o, 32'd65535);
    drive(1'b1, 5'd0, 1'b0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    tick();
    @(negedge clk_i);
    chk("wrap_ipm_zero", 32'(ipm_retire_cnt_o), 32'd0);
    chk("wrap_retire", retire_cnt_o, 32'd65536);

    chk("sb_all_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
